alu_mb_seq: RTL and testbench

- Multi-byte sequencer for the shared 8-bit combinational ALU.
- Accepts one wide operation (NBYTES bytes) per start pulse and issues it to the ALU one byte per cycle, chaining carry/shift bits through the ALU carry port.
- Registers the wide result and its flags, then pulses done.
- Sits between the core's control logic and the ALU instance; the ALU stays outside this block.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_mb_seq.sv | 138 +++++++++++++
 tb/tb_alu_mb_seq.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------+
// | alu_pkg                                                       |
// | Shared ALU command encoding and sequencer state types.        |
// | Rev 1.0 - initial release                                     |
// +---------------------------------------------------------------+
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    LSH  = 4'd1,
    RSH  = 4'd2,
    MOV  = 4'd3,
    OR   = 4'd4,
    XOR  = 4'd5,
    AND  = 4'd6,
    ADDI = 4'd7
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Commands whose carry/shift bit chains from one byte to the next.
  function automatic logic uses_carry(input alu_cmd_t cmd);
    return (cmd == ADD) || (cmd == LSH) || (cmd == RSH) || (cmd == ADDI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mb_seq.sv
`default_nettype none
// +---------------------------------------------------------------+
// | alu_mb_seq                                                    |
// | Issues one NBYTES-wide op to the external 8-bit ALU bytewise. |
// | Rev 1.0 - initial release                                     |
// +---------------------------------------------------------------+
module alu_mb_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2:0]          op,
  input  logic [8*NBYTES-1:0] opA,
  input  logic [8*NBYTES-1:0] opB,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                zero,
  output logic                pari,
  output logic [3:0]          alu_cmd,
  output logic [7:0]          alu_inA,
  output logic [7:0]          alu_inB,
  output logic                alu_sc_i,
  input  logic [7:0]          alu_rslt,
  input  logic                alu_sc_o
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] C_LAST = CW'(NBYTES - 1);

  seq_state_t    state_q, state_d;
  alu_cmd_t      op_q, op_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, work_q, work_d, result_q, result_d;
  logic [CW-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic          carry_q, carry_d, cout_q, cout_d, zero_q, zero_d, pari_q, pari_d;
  logic          w_chain;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    pari_d   = pari_q;
    alu_cmd  = 4'd0;
    alu_inA  = 8'd0;
    alu_inB  = 8'd0;
    alu_sc_i = 1'b0;
    w_chain  = uses_carry(op_q);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          op_d    = alu_cmd_t'({1'b0, op});
          a_d     = opA;
          b_d     = opB;
          work_d  = '0;
          carry_d = cin;
          cnt_d   = '0;
          // Right shift walks from the MSB byte down so the shift-in enters at the top.
          idx_d   = (op == 3'd2) ? C_LAST : '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        alu_cmd  = op_q;
        alu_inA  = a_q[int'(idx_q)*8 +: 8];
        alu_inB  = b_q[int'(idx_q)*8 +: 8];
        alu_sc_i = w_chain ? carry_q : 1'b0;
        work_d[int'(idx_q)*8 +: 8] = alu_rslt;
        carry_d  = w_chain ? alu_sc_o : 1'b0;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = (op_q == RSH) ? idx_q - CW'(1) : idx_q + CW'(1);
        if (cnt_q == C_LAST) begin
          state_d  = DONE;
          result_d = work_d;
          cout_d   = carry_d;
          zero_d   = ~|work_d;
          pari_d   = ^work_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= ADD;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      pari_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      pari_q   <= pari_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;
  assign pari   = pari_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mb_seq.sv
`default_nettype none
// +---------------------------------------------------------------+
// | tb_alu_mb_seq                                                 |
// | Directed self-checking bench with a behavioural 8-bit ALU.    |
// | Rev 1.0 - initial release                                     |
// +---------------------------------------------------------------+
module tb_alu_mb_seq;

  localparam int NBYTES = 2;
  localparam int W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         reset, start, cin;
  logic [2:0]   op;
  logic [W-1:0] opA, opB;
  logic         busy, done, cout, zero, pari;
  logic [W-1:0] result;
  logic [3:0]   alu_cmd;
  logic [7:0]   alu_inA, alu_inB, alu_rslt;
  logic         alu_sc_i, alu_sc_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_mb_seq #(.NBYTES(NBYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB),
    .cin(cin), .busy(busy), .done(done), .result(result), .cout(cout),
    .zero(zero), .pari(pari), .alu_cmd(alu_cmd), .alu_inA(alu_inA),
    .alu_inB(alu_inB), .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt),
    .alu_sc_o(alu_sc_o)
  );

  // Reference 8-bit ALU standing in for the shared instance.
  always_comb begin
    logic [8:0] sum;
    sum      = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'd0, alu_sc_i};
    alu_rslt = 8'd0;
    alu_sc_o = 1'b0;
    case (alu_cmd)
      4'd0, 4'd7: begin alu_rslt = sum[7:0]; alu_sc_o = sum[8]; end
      4'd1: begin alu_rslt = {alu_inA[6:0], alu_sc_i}; alu_sc_o = alu_inA[7]; end
      4'd2: begin alu_rslt = {alu_sc_i, alu_inA[7:1]}; alu_sc_o = alu_inA[0]; end
      4'd3: alu_rslt = alu_inA;
      4'd4: alu_rslt = alu_inA | alu_inB;
      4'd5: alu_rslt = alu_inA ^ alu_inB;
      4'd6: alu_rslt = alu_inA & alu_inB;
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
    op = o; opA = a; opB = b; cin = c; start = 1'b1;
  endtask

  // Full op from an idle bench: start, two RUN cycles, then the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c, input logic [7:0] ina0,
                        input logic [7:0] ina1, input logic [W-1:0] exp_res,
                        input logic exp_cout, input logic exp_zero, input logic exp_pari);
    @(negedge clk);
    launch(o, a, b, c);
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy1"}, busy, 1);
    check({tag, " inA1"}, alu_inA, ina0);
    check({tag, " cmd"}, alu_cmd, {1'b0, o});
    @(negedge clk);
    check({tag, " busy2"}, busy, 1);
    check({tag, " inA2"}, alu_inA, ina1);
    @(negedge clk);
    check({tag, " done"}, {busy, done}, 2'b01);
    check({tag, " result"}, result, exp_res);
    check({tag, " flags"}, {cout, zero, pari}, {exp_cout, exp_zero, exp_pari});
    check({tag, " cmd idle"}, {alu_cmd, alu_inA, alu_sc_i}, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; opA = '0; opB = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset state", {busy, done, cout, zero, pari}, 0);
    check("reset result", result, 0);
    check("reset alu", {alu_cmd, alu_inA, alu_inB, alu_sc_i}, 0);
    reset = 1'b0;

    run_op("add ripple", 3'd0, 16'h00FF, 16'h0001, 1'b0, 8'hFF, 8'h00, 16'h0100, 0, 0, 1);
    @(negedge clk);
    check("idle after done", {busy, done}, 0);
    run_op("add ovf", 3'd0, 16'hFFFF, 16'h0001, 1'b0, 8'hFF, 8'hFF, 16'h0000, 1, 1, 0);
    run_op("lsh", 3'd1, 16'h8001, 16'h0000, 1'b1, 8'h01, 8'h80, 16'h0003, 1, 0, 0);
    run_op("rsh", 3'd2, 16'h0001, 16'h0000, 1'b1, 8'h00, 8'h01, 16'h8000, 1, 0, 1);
    run_op("and", 3'd6, 16'hF0F0, 16'hFF00, 1'b1, 8'hF0, 8'hF0, 16'hF000, 0, 0, 0);

    // Handshake: start during RUN ignored, start in DONE accepted back-to-back.
    @(negedge clk);
    launch(3'd5, 16'h1234, 16'h00FF, 1'b0);
    @(negedge clk);
    check("hs busy1", busy, 1);
    launch(3'd0, 16'h0F0F, 16'h0F0F, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("hs busy2", busy, 1);
    @(negedge clk);
    check("hs done", {busy, done}, 2'b01);
    check("hs result", result, 16'h12CB);
    check("hs flags", {cout, pari}, 2'b01);
    launch(3'd0, 16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("hs2 busy1", {busy, done}, 2'b10);
    check("hs2 hold1", result, 16'h12CB);
    @(negedge clk);
    check("hs2 hold2", result, 16'h12CB);
    @(negedge clk);
    check("hs2 done", {busy, done}, 2'b01);
    check("hs2 result", result, 16'h0002);

    // Reset during the first RUN cycle.
    @(negedge clk);
    launch(3'd0, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("rst busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst abort", {busy, done, cout, zero, pari}, 0);
    check("rst result", result, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst no done", {busy, done}, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
